// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: bus widths, instruction field
// positions and the fetch-buffer entry layout.
package cpu4_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  // Instruction fields: opcode in the high nibble, immediate in the low nibble.
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  // One buffered fetch: the word and the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the instruction buffer.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   flush        - drop all entries (pointers and count to zero)
//   push, wdata  - write an entry at the tail
//   pop          - remove the head entry
//   rdata        - head entry (stale when empty)
//   count        - number of stored entries
//   full         - count == DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import cpu4_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign pop_ok  = pop && (cnt_q != '0);
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // Cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational program
// memory, buffers {pc, word} entries and offers them over valid/ready.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   run_en, step                - free-run enable / single-fetch pulse
//   mem_addr, mem_data          - program memory read port (same-cycle data)
//   redirect_valid, redirect_pc - jump: flush buffer, load PC (top priority)
//   instr_valid, instr_ready    - head-of-buffer handshake
//   instr, instr_pc             - head word and its fetch address
//   pc_out                      - current PC for display
//   buf_count                   - buffered entry count
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run_en,
  input  logic                         step,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [DATA_W-1:0]            instr,
  output logic [ADDR_W-1:0]            instr_pc,
  output logic [ADDR_W-1:0]            pc_out,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic                   fetch_req, push, pop, full;
  cpu4_pkg::fetch_entry_t wentry, head;

  assign mem_addr  = pc_q;
  assign pc_out    = pc_q;
  assign fetch_req = run_en | step;

  // Valid looks only at stored state and redirect, never at instr_ready.
  assign instr_valid = (buf_count != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign push        = fetch_req && !redirect_valid && (!full || pop);

  assign wentry.pc   = pc_q;
  assign wentry.word = mem_data;
  assign instr       = head.word;
  assign instr_pc    = head.pc;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (buf_count),
    .full  (full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational program ROM.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, run_en, step, redirect_valid, instr_ready, instr_valid;
  logic [3:0] mem_addr, redirect_pc, instr_pc, pc_out;
  logic [7:0] mem_data, instr;
  logic [1:0] buf_count;
  logic [7:0] rom [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_data = rom[mem_addr];

  instr_fetch_unit #(
    .ADDR_W    (4),
    .DATA_W    (8),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run_en         (run_en),
    .step           (step),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_out         (pc_out),
    .buf_count      (buf_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: through the rising edge, stop at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Hand-written expectations for the first four in-order fetches.
  logic [7:0] exp_w [4];

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = 8'hB0;
    rom[0] = 8'h08; rom[1] = 8'h19; rom[2] = 8'h20; rom[3] = 8'h10;
    rom[4] = 8'h70; rom[5] = 8'h00; rom[6] = 8'h14; rom[7] = 8'h04;
    rom[8] = 8'hB2;
    exp_w[0] = 8'h08; exp_w[1] = 8'h19; exp_w[2] = 8'h20; exp_w[3] = 8'h10;

    reset = 1'b1; run_en = 1'b0; step = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 4'd0; instr_ready = 1'b0;

    // Reset state
    cyc();
    chk("rst_pc", 16'(pc_out), 16'h0);
    chk("rst_addr", 16'(mem_addr), 16'h0);
    chk("rst_cnt", 16'(buf_count), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_instr", 16'(instr), 16'h0);
    chk("rst_ipc", 16'(instr_pc), 16'h0);

    // Free run with ready: one instruction per cycle from cycle 1
    reset = 1'b0; run_en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("run_valid", 16'(instr_valid), 16'h1);
      chk("run_ipc", 16'(instr_pc), 16'(i));
      chk("run_instr", 16'(instr), 16'(exp_w[i]));
    end

    // Back-pressure: buffer fills to 2, PC freezes at 2
    reset = 1'b1; cyc();
    reset = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("bp_pc3", 16'(pc_out), 16'h2);
    cyc(); cyc();
    chk("bp_cnt", 16'(buf_count), 16'h2);
    chk("bp_pc5", 16'(pc_out), 16'h2);
    chk("bp_addr", 16'(mem_addr), 16'h2);
    instr_ready = 1'b1;
    #1;
    chk("rel_w0", 16'(instr), 16'h08);
    chk("rel_v0", 16'(instr_valid), 16'h1);
    cyc();
    chk("rel_w1", 16'(instr), 16'h19);
    chk("rel_cnt", 16'(buf_count), 16'h2);
    chk("rel_pc", 16'(pc_out), 16'h3);
    cyc();
    chk("rel_w2", 16'(instr), 16'h20);
    chk("rel_ipc2", 16'(instr_pc), 16'h2);

    // Wrap: head is pc2, PC=4; 13 cycles brings pc15 to the head
    for (int i = 0; i < 13; i++) cyc();
    chk("wrap_ipc", 16'(instr_pc), 16'hF);
    chk("wrap_w", 16'(instr), 16'hB0);
    chk("wrap_pc", 16'(pc_out), 16'h1);
    cyc();
    chk("wrap_ipc0", 16'(instr_pc), 16'h0);
    chk("wrap_w0", 16'(instr), 16'h08);

    // Redirect while full
    instr_ready = 1'b0;
    cyc();
    chk("pre_rd_cnt", 16'(buf_count), 16'h2);
    redirect_valid = 1'b1; redirect_pc = 4'd8;
    #1;
    chk("rd_valid", 16'(instr_valid), 16'h0);
    cyc();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("rd_cnt", 16'(buf_count), 16'h0);
    chk("rd_pc", 16'(pc_out), 16'h8);
    chk("rd_valid1", 16'(instr_valid), 16'h0);
    cyc();
    chk("rd_v2", 16'(instr_valid), 16'h1);
    chk("rd_ipc", 16'(instr_pc), 16'h8);
    chk("rd_w", 16'(instr), 16'hB2);

    // Single step
    run_en = 1'b0; instr_ready = 1'b0;
    do_reset();
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("st_cnt", 16'(buf_count), 16'h1);
    chk("st_pc", 16'(pc_out), 16'h1);
    chk("st_w", 16'(instr), 16'h08);
    chk("st_ipc", 16'(instr_pc), 16'h0);
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_cnt", 16'(buf_count), 16'h1);
    chk("idle_pc", 16'(pc_out), 16'h1);
    step = 1'b1; cyc(); step = 1'b0;
    chk("st2_cnt", 16'(buf_count), 16'h2);
    chk("st2_pc", 16'(pc_out), 16'h2);
    step = 1'b1; cyc(); step = 1'b0;
    chk("stfull_pc", 16'(pc_out), 16'h2);
    chk("stfull_cnt", 16'(buf_count), 16'h2);
    cyc();
    chk("stfull_pc2", 16'(pc_out), 16'h2);

    // Reset mid-operation at PC=5 with a full buffer
    do_reset();
    run_en = 1'b1;
    cyc(); cyc();
    instr_ready = 1'b1;
    cyc(); cyc(); cyc();
    instr_ready = 1'b0;
    #1;
    chk("mid_pc", 16'(pc_out), 16'h5);
    chk("mid_cnt", 16'(buf_count), 16'h2);
    reset = 1'b1; cyc(); reset = 1'b0;
    #1;
    chk("mr_pc", 16'(pc_out), 16'h0);
    chk("mr_cnt", 16'(buf_count), 16'h0);
    chk("mr_valid", 16'(instr_valid), 16'h0);
    chk("mr_instr", 16'(instr), 16'h0);
    cyc();
    chk("mr_v1", 16'(instr_valid), 16'h1);
    chk("mr_ipc", 16'(instr_pc), 16'h0);
    chk("mr_w", 16'(instr), 16'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
